wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
//  Shares the single writeback/completion port between the execution units (scalu, imul, lsq, branch).
//  Each cycle it grants one valid requester by round-robin and registers that requester's result into the wb stage.
//  The wb stage drives the ROB/regfile completion bus; every non-granted requester receives stall and holds.
//  Sits between the FU output registers and the ROB.
// PARAMETERS
//  NREQ     4   number of requesters; index 0=scalu,1=imul,2=lsq,3=branch
//  ROBW     7   robid width
//  RDW      6   destination register tag width
//  DW       32  result width
// PORTS
//  clk           in   1          clock, all state on rising edge
//  rst           in   1          asynchronous, active-low reset
//  req_valid     in   NREQ       requester i has a completed op
//  req_error     in   NREQ       requester i op raised exception
//  req_ecause    in   5*NREQ     exception cause, slice i = [5i+4:5i]
//  req_robid     in   ROBW*NREQ  ROB entry of requester i
//  req_rd        in   RDW*NREQ   destination tag of requester i
//  req_result    in   DW*NREQ    result of requester i
//  req_stall     out  NREQ       requester i must hold its outputs this cycle
//  wb_valid      out  1          wb stage holds a completion
//  wb_error      out  1          registered error of granted op
//  wb_ecause     out  5          registered cause
//  wb_robid      out  ROBW       registered robid
//  wb_rd         out  RDW        registered rd
//  wb_result     out  DW         registered result
//  rob_wb_stall  in   1          ROB cannot accept wb stage this cycle
//  rob_flush     in   1          pipeline flush, synchronous
// BEHAVIOUR
//  Reset (rst=0, async): wb_valid=0, wb_error=0, wb_ecause/robid/rd/result=0, rr_ptr=0.
//  load = ~wb_valid | ~rob_wb_stall (wb stage empty or draining this cycle).
//  Arbitration: combinational; search starts at rr_ptr, ascending mod NREQ; first req_valid wins -> grant (one-hot or 0).
//  accept = load & ~rob_flush & |grant.
//  req_stall[i] = req_valid[i] & ~(accept & grant[i]) & ~rob_flush; ~req_valid -> stall=0.
//  On accept: wb_* <= granted slices, wb_valid <= 1, rr_ptr <= (grant index + 1) mod NREQ.
//  load & no grant & ~rob_flush: wb_valid <= 0; data regs and rr_ptr hold.
//  ~load & ~rob_flush: all wb_* and rr_ptr hold (ROB backpressure); every valid requester stalled.
//  rob_flush: wb_valid <= 0 next edge regardless of rob_wb_stall; no grant; req_stall=0; rr_ptr holds.
//  Latency: req_valid high at edge N with grant -> wb_valid at edge N+1. Throughput 1 completion/cycle.
//  Fairness: a continuously valid requester is accepted within NREQ accepts.
//  Wrap: rr_ptr increment wraps NREQ-1 -> 0; NREQ non-power-of-2 must wrap correctly.
//  wb_error/wb_ecause pass through unmodified; arbiter never generates errors.
//  No combinational path from rob_wb_stall to wb_* data; wb_* are pure flops.
// STRUCTURE
//  Shared package wb_pkg: NREQ, ROBW, RDW, DW, requester index constants (WB_SCALU..WB_BRANCH).
//  Sub-module rr_arbiter #(N): inputs req[N], ptr[clog2 N]; output gnt[N] one-hot; purely combinational.
//  wb_arbiter: slice mux driven by gnt, rr_ptr register, wb stage register, stall logic.
// TESTING
//  Single req: req_valid=0001, robid0=7'h05, result0=32'hDEAD -> next cycle wb_valid=1, wb_robid=05, wb_result=DEAD; req_stall=0.
//  All four valid continuously, rr_ptr=0 -> wb_robid sequence 0,1,2,3,0 grants; stall on the three losers each cycle.
//  rob_wb_stall=1 for 3 cycles with wb_valid=1 -> wb_* unchanged, req_stall=req_valid, rr_ptr unchanged; release -> next grant.
//  rob_flush with wb_valid=1 and rob_wb_stall=1 -> wb_valid=0 next cycle, req_stall=0 during flush, rr_ptr held.
//  Async reset asserted mid-stream (between edges) -> wb_valid=0 immediately; after release first grant from index 0.
//  Error passthrough: req 2 valid with error=1, ecause=5'd4 -> wb_error=1, wb_ecause=4, wb_rd=req_rd slice 2.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared widths and requester indices for the writeback arbiter.
package wb_pkg;

  localparam int NREQ = 4;
  localparam int ROBW = 7;
  localparam int RDW  = 6;
  localparam int DW   = 32;
  localparam int ECW  = 5;
  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam int WB_SCALU  = 0;
  localparam int WB_IMUL   = 1;
  localparam int WB_LSQ    = 2;
  localparam int WB_BRANCH = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Search starts at ptr and ascends modulo N; the first requester wins.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  always_comb begin
    int idx;
    idx = 0;
    gnt = '0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (gnt == '0 && req[idx])
        gnt[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback port arbiter: picks one FU result per cycle
// round-robin and registers it into the wb stage.
module wb_arbiter
  import wb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_error,
  input  logic [ECW*NREQ-1:0]  req_ecause,
  input  logic [ROBW*NREQ-1:0] req_robid,
  input  logic [RDW*NREQ-1:0]  req_rd,
  input  logic [DW*NREQ-1:0]   req_result,
  output logic [NREQ-1:0]      req_stall,
  output logic                 wb_valid,
  output logic                 wb_error,
  output logic [ECW-1:0]       wb_ecause,
  output logic [ROBW-1:0]      wb_robid,
  output logic [RDW-1:0]       wb_rd,
  output logic [DW-1:0]        wb_result,
  input  logic                 rob_wb_stall,
  input  logic                 rob_flush
);

  logic [NREQ-1:0] gnt;
  logic [PTRW-1:0] rr_ptr;
  logic [PTRW-1:0] gidx;
  logic [PTRW-1:0] ptr_nxt;
  logic            load;
  logic            accept;
  logic            g_err;
  logic [ECW-1:0]  g_ec;
  logic [ROBW-1:0] g_robid;
  logic [RDW-1:0]  g_rd;
  logic [DW-1:0]   g_res;

  rr_arbiter #(.N(NREQ), .PW(PTRW)) u_rr (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt)
  );

  always_comb begin
    gidx    = '0;
    g_err   = 1'b0;
    g_ec    = '0;
    g_robid = '0;
    g_rd    = '0;
    g_res   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        gidx    = PTRW'(i);
        g_err   = req_error[i];
        g_ec    = req_ecause[i*ECW +: ECW];
        g_robid = req_robid[i*ROBW +: ROBW];
        g_rd    = req_rd[i*RDW +: RDW];
        g_res   = req_result[i*DW +: DW];
      end
    end
  end

  // explicit wrap so a non-power-of-2 NREQ never lands on a dead index
  assign ptr_nxt = (gidx == PTRW'(NREQ-1)) ? '0 : gidx + 1'b1;

  assign load   = ~wb_valid | ~rob_wb_stall;
  assign accept = load & ~rob_flush & (|gnt);

  assign req_stall = req_valid
                   & ~({NREQ{accept}} & gnt)
                   & ~{NREQ{rob_flush}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid  <= 1'b0;
      wb_error  <= 1'b0;
      wb_ecause <= '0;
      wb_robid  <= '0;
      wb_rd     <= '0;
      wb_result <= '0;
      rr_ptr    <= '0;
    end else if (rob_flush) begin
      wb_valid <= 1'b0;
    end else if (accept) begin
      wb_valid  <= 1'b1;
      wb_error  <= g_err;
      wb_ecause <= g_ec;
      wb_robid  <= g_robid;
      wb_rd     <= g_rd;
      wb_result <= g_res;
      rr_ptr    <= ptr_nxt;
    end else if (load) begin
      wb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter against a
// transaction-level round-robin reference model.
module tb_wb_arbiter;
  import wb_pkg::*;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_error;
  logic [ECW*NREQ-1:0]  req_ecause;
  logic [ROBW*NREQ-1:0] req_robid;
  logic [RDW*NREQ-1:0]  req_rd;
  logic [DW*NREQ-1:0]   req_result;
  logic [NREQ-1:0]      req_stall;
  logic                 wb_valid;
  logic                 wb_error;
  logic [ECW-1:0]       wb_ecause;
  logic [ROBW-1:0]      wb_robid;
  logic [RDW-1:0]       wb_rd;
  logic [DW-1:0]        wb_result;
  logic                 rob_wb_stall;
  logic                 rob_flush;

  int total;
  int bad;

  // reference model state
  int              m_ptr;
  bit              m_valid;
  logic            m_err;
  logic [ECW-1:0]  m_ec;
  logic [ROBW-1:0] m_robid;
  logic [RDW-1:0]  m_rd;
  logic [DW-1:0]   m_res;

  wb_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_error    (req_error),
    .req_ecause   (req_ecause),
    .req_robid    (req_robid),
    .req_rd       (req_rd),
    .req_result   (req_result),
    .req_stall    (req_stall),
    .wb_valid     (wb_valid),
    .wb_error     (wb_error),
    .wb_ecause    (wb_ecause),
    .wb_robid     (wb_robid),
    .wb_rd        (wb_rd),
    .wb_result    (wb_result),
    .rob_wb_stall (rob_wb_stall),
    .rob_flush    (rob_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // index of the winning requester, or -1 if none
  function automatic int m_winner();
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (m_ptr + k) % NREQ;
      if (req_valid[j]) return j;
    end
    return -1;
  endfunction

  function automatic bit m_accept();
    bit ld;
    ld = !m_valid || !rob_wb_stall;
    return ld && !rob_flush && (m_winner() >= 0);
  endfunction

  function automatic logic [NREQ-1:0] m_stall();
    logic [NREQ-1:0] s;
    int w;
    w = m_winner();
    s = '0;
    if (!rob_flush)
      for (int i = 0; i < NREQ; i++)
        s[i] = req_valid[i] && !(m_accept() && w == i);
    return s;
  endfunction

  task automatic m_clock();
    int w;
    bit ld;
    w  = m_winner();
    ld = !m_valid || !rob_wb_stall;
    if (rob_flush) m_valid = 0;
    else if (ld && w >= 0) begin
      m_valid = 1;
      m_err   = req_error[w];
      m_ec    = req_ecause[w*ECW +: ECW];
      m_robid = req_robid[w*ROBW +: ROBW];
      m_rd    = req_rd[w*RDW +: RDW];
      m_res   = req_result[w*DW +: DW];
      m_ptr   = (w + 1) % NREQ;
    end else if (ld) m_valid = 0;
  endtask

  task automatic m_reset();
    m_ptr = 0; m_valid = 0; m_err = 0; m_ec = '0;
    m_robid = '0; m_rd = '0; m_res = '0;
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_error = '0; req_ecause = '0;
    req_robid = '0; req_rd = '0; req_result = '0;
    rob_wb_stall = 0; rob_flush = 0;
  endtask

  task automatic set_req(int i, logic [ROBW-1:0] rb,
                         logic [DW-1:0] res);
    req_valid[i] = 1'b1;
    req_robid[i*ROBW +: ROBW] = rb;
    req_result[i*DW +: DW] = res;
    req_rd[i*RDW +: RDW] = RDW'(i + 8);
  endtask

  task automatic test_reset();
    rst = 0;
    idle_inputs();
    m_reset();
    #12;
    total++;
    if (wb_valid !== 1'b0 || wb_robid !== '0 || wb_result !== '0
        || wb_error !== 1'b0 || wb_ecause !== '0 || wb_rd !== '0) begin
      bad++;
      $display("FAIL reset: valid=%b robid=%h result=%h exp all zero",
               wb_valid, wb_robid, wb_result);
    end
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    idle_inputs();
    set_req(0, 7'h05, 32'hDEAD);
    #1;
    total++;
    if (req_stall !== 4'b0000) begin
      bad++;
      $display("FAIL single_stall: got=%b exp=0000", req_stall);
    end
    @(posedge clk); m_clock(); #1;
    total++;
    if (wb_valid !== 1'b1 || wb_robid !== 7'h05
        || wb_result !== 32'hDEAD) begin
      bad++;
      $display("FAIL single_wb: v=%b robid=%h res=%h exp 1/05/DEAD",
               wb_valid, wb_robid, wb_result);
    end
    idle_inputs();
    @(posedge clk); m_clock(); #1;
  endtask

  task automatic test_round_robin();
    int start;
    idle_inputs();
    for (int i = 0; i < NREQ; i++) set_req(i, 7'(i), 32'(i * 16));
    start = m_ptr;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++;
      if (req_stall !== m_stall() || $countones(req_stall) != NREQ-1) begin
        bad++;
        $display("FAIL rr_stall c=%0d: got=%b exp=%b", c, req_stall, m_stall());
      end
      @(posedge clk); m_clock(); #1;
      total++;
      if (!wb_valid || wb_robid !== 7'((start + c) % NREQ)) begin
        bad++;
        $display("FAIL rr_seq c=%0d: robid=%h exp=%h", c, wb_robid,
                 7'((start + c) % NREQ));
      end
    end
  endtask

  task automatic test_back_to_back_stall();
    logic [ROBW-1:0] hold_rb;
    logic [DW-1:0]   hold_res;
    int              ptr0;
    idle_inputs();
    for (int i = 0; i < NREQ; i++) set_req(i, 7'(i + 32), 32'(i + 100));
    @(posedge clk); m_clock(); #1;
    hold_rb = wb_robid; hold_res = wb_result; ptr0 = m_ptr;
    rob_wb_stall = 1;
    for (int c = 0; c < 3; c++) begin
      req_valid = 4'(($urandom_range(1, 15)));
      #1;
      total++;
      if (req_stall !== req_valid) begin
        bad++;
        $display("FAIL bp_stall c=%0d: got=%b exp=%b", c, req_stall, req_valid);
      end
      @(posedge clk); m_clock(); #1;
      total++;
      if (!wb_valid || wb_robid !== hold_rb || wb_result !== hold_res) begin
        bad++;
        $display("FAIL bp_hold c=%0d: v=%b robid=%h exp=%h", c,
                 wb_valid, wb_robid, hold_rb);
      end
    end
    rob_wb_stall = 0;
    req_valid = '1;
    @(posedge clk); m_clock(); #1;
    total++;
    if (wb_robid !== 7'(ptr0 + 32)) begin
      bad++;
      $display("FAIL bp_release: robid=%h exp=%h", wb_robid, 7'(ptr0 + 32));
    end
  endtask

  task automatic test_flush();
    int ptr0;
    idle_inputs();
    for (int i = 0; i < NREQ; i++) set_req(i, 7'(i + 64), 32'(i));
    @(posedge clk); m_clock(); #1;
    ptr0 = m_ptr;
    rob_wb_stall = 1;
    rob_flush = 1;
    #1;
    total++;
    if (req_stall !== 4'b0000) begin
      bad++;
      $display("FAIL flush_stall: got=%b exp=0000", req_stall);
    end
    @(posedge clk); m_clock(); #1;
    total++;
    if (wb_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_valid: got=%b exp=0", wb_valid);
    end
    rob_flush = 0;
    rob_wb_stall = 0;
    @(posedge clk); m_clock(); #1;
    total++;
    if (!wb_valid || wb_robid !== 7'(ptr0 + 64)) begin
      bad++;
      $display("FAIL flush_ptr: robid=%h exp=%h", wb_robid, 7'(ptr0 + 64));
    end
  endtask

  task automatic test_async_reset();
    idle_inputs();
    for (int i = 0; i < NREQ; i++) set_req(i, 7'(i + 80), 32'(i));
    @(posedge clk); m_clock(); #1;
    @(posedge clk); m_clock(); #2;
    rst = 0;
    #1;
    m_reset();
    total++;
    if (wb_valid !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: wb_valid=%b exp=0", wb_valid);
    end
    @(negedge clk);
    rst = 1;
    @(posedge clk); m_clock(); #1;
    total++;
    if (!wb_valid || wb_robid !== 7'd80) begin
      bad++;
      $display("FAIL reset_first_grant: robid=%h exp=50", wb_robid);
    end
  endtask

  task automatic test_error();
    idle_inputs();
    set_req(2, 7'h11, 32'h1234);
    req_error[2] = 1'b1;
    req_ecause[2*ECW +: ECW] = 5'd4;
    req_rd[2*RDW +: RDW] = 6'h2a;
    @(posedge clk); m_clock(); #1;
    total++;
    if (wb_error !== 1'b1 || wb_ecause !== 5'd4 || wb_rd !== 6'h2a) begin
      bad++;
      $display("FAIL error_pass: err=%b cause=%0d rd=%h exp 1/4/2a",
               wb_error, wb_ecause, wb_rd);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      req_valid    = 4'($urandom);
      req_error    = 4'($urandom);
      req_ecause   = 20'($urandom);
      req_robid    = 28'($urandom);
      req_rd       = 24'($urandom);
      req_result   = {$urandom, $urandom, $urandom, $urandom};
      rob_wb_stall = ($urandom_range(0, 3) == 0);
      rob_flush    = ($urandom_range(0, 9) == 0);
      #1;
      total++;
      if (req_stall !== m_stall()) begin
        bad++;
        $display("FAIL rand_stall c=%0d: got=%b exp=%b", c, req_stall, m_stall());
      end
      @(posedge clk); m_clock(); #1;
      total++;
      if (wb_valid !== m_valid || wb_error !== m_err
          || wb_ecause !== m_ec || wb_robid !== m_robid
          || wb_rd !== m_rd || wb_result !== m_res) begin
        bad++;
        $display("FAIL rand_wb c=%0d: v=%b rb=%h res=%h exp v=%b rb=%h res=%h",
                 c, wb_valid, wb_robid, wb_result, m_valid, m_robid, m_res);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back_stall();
    test_flush();
    test_async_reset();
    test_error();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
